// File: rtl/manchester_rx_fsm_pkg.sv
// manchester_pkg: shared Manchester framing constants and receiver state type
package manchester_pkg;

   typedef enum logic [1:0] {IDLE, RECV, HOLDOFF} rx_state_t;

   localparam logic [7:0] PREAMBLE = 8'h55;
   localparam int WIN_EARLY_NUM = 3;
   localparam int WIN_LATE_NUM = 5;
   localparam int WIN_DEN = 4;

   function automatic int win_clks(input int bit_clks, input int num);
      return bit_clks * num / WIN_DEN;
   endfunction

endpackage

// File: rtl/manchester_rx_fsm_if.sv
// manchester_rx_fsm_if: serial line in, decoded byte stream and frame status out
interface manchester_rx_fsm_if #(parameter int D = 8) ();

   logic rxd;
   logic [D-1:0] data;
   logic data_valid;
   logic cardet;
   logic eof;
   logic error;

   modport master (input rxd, output data, data_valid, cardet, eof, error);
   modport slave (output rxd, input data, data_valid, cardet, eof, error);

endinterface

// File: rtl/manchester_rx_fsm_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus delay flop with rise/fall detect
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic rxd,
   output logic rxd_s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic rxd_d;

   always_ff @(posedge clk or negedge reset)
      if (!reset) {meta, rxd_s, rxd_d} <= 3'b111;
      else {meta, rxd_s, rxd_d} <= {rxd, meta, rxd_s};

   assign rise = rxd_s & ~rxd_d;
   assign fall = ~rxd_s & rxd_d;

endmodule

// File: rtl/manchester_rx_fsm.sv
// manchester_rx_fsm: windowed Manchester decoder with EOF timeout and holdoff
module manchester_rx_fsm
   import manchester_pkg::*;
#(
   parameter int BIT_CLKS = 16,
   parameter int D = 8
) (
   input logic clk,
   input logic reset,
   manchester_rx_fsm_if.master rx
);

   localparam int EARLY = win_clks(BIT_CLKS, WIN_EARLY_NUM);
   localparam int LATE = win_clks(BIT_CLKS, WIN_LATE_NUM);
   localparam int TW = $clog2(LATE + 1);
   localparam int HW = $clog2(BIT_CLKS + 1);
   localparam int BW = $clog2(D);

   rx_state_t state;
   logic [TW-1:0] timer;
   logic [HW-1:0] hold_cnt;
   logic [BW-1:0] bit_cnt;
   logic [D-1:0] shreg;
   logic [D-1:0] nxt_sh;
   logic early_seen;
   logic rxd_s;
   logic rise;
   logic fall;
   logic chg;
   logic early;
   logic timeout;
   logic last_bit;

   sync_edge_det u_sync (
      .clk  (clk),
      .reset(reset),
      .rxd  (rx.rxd),
      .rxd_s(rxd_s),
      .rise (rise),
      .fall (fall)
   );

   // timer reads one less than the clocks elapsed when an edge is judged, hence EARLY-1
   assign chg = rise | fall;
   assign early = timer < TW'(EARLY - 1);
   assign timeout = timer == TW'(LATE);
   assign nxt_sh = {fall, shreg[D-1:1]};
   assign last_bit = bit_cnt == BW'(D - 1);

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         timer <= '0;
         hold_cnt <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         early_seen <= 1'b0;
         rx.data <= '0;
         rx.data_valid <= 1'b0;
         rx.cardet <= 1'b0;
         rx.eof <= 1'b0;
         rx.error <= 1'b0;
      end else begin
         rx.data_valid <= 1'b0;
         rx.eof <= 1'b0;
         rx.error <= 1'b0;
         timer <= timeout ? timer : timer + 1'b1;
         case (state)
            IDLE:
               if (fall) begin
                  state <= RECV;
                  rx.cardet <= 1'b1;
                  shreg <= {PREAMBLE[0], shreg[D-1:1]};
                  bit_cnt <= BW'(1);
                  timer <= '0;
                  early_seen <= 1'b0;
               end
            RECV:
               if (timeout || (chg && early && early_seen)) begin
                  state <= HOLDOFF;
                  rx.cardet <= 1'b0;
                  hold_cnt <= '0;
                  rx.eof <= timeout && bit_cnt == '0;
                  rx.error <= !(timeout && bit_cnt == '0);
                  bit_cnt <= '0;
               end else if (chg && early) begin
                  early_seen <= 1'b1;
               end else if (chg) begin
                  timer <= '0;
                  early_seen <= 1'b0;
                  shreg <= nxt_sh;
                  bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                  rx.data <= last_bit ? nxt_sh : rx.data;
                  rx.data_valid <= last_bit;
               end
            HOLDOFF:
               if (!rxd_s) hold_cnt <= '0;
               else if (hold_cnt == HW'(BIT_CLKS - 1)) state <= IDLE;
               else hold_cnt <= hold_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_manchester_rx_fsm.sv
// tb_manchester_rx_fsm: waveform-level reference model feeding an event scoreboard
module tb_manchester_rx_fsm;

   localparam int BC = 16;
   localparam int D = 8;
   localparam int EARLY = 3 * BC / 4;
   localparam int LATE = 5 * BC / 4;

   typedef struct {
      int kind;
      logic [7:0] data;
      int at;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   ev_t exp_q[$];
   bit lv[$];

   manchester_rx_fsm_if #(.D(D)) rx ();

   manchester_rx_fsm #(.BIT_CLKS(BC), .D(D)) dut (
      .clk  (clk),
      .reset(reset),
      .rx   (rx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // line index j is acted on two clocks later; kinds: 0 byte, 1 eof, 2 error
   function automatic void model(input int base);
      int n = lv.size();
      int j = 1;
      int ta, early, te, kind, run;
      bit bq[$];
      logic [7:0] v;
      while (j < n) begin
         if (lv[j-1] == 1'b0 || lv[j] == 1'b1) begin
            j++;
            continue;
         end
         ta = j;
         bq.delete();
         bq.push_back(1'b1);
         early = 0;
         te = -1;
         kind = 2;
         for (int t = ta + 1; t < n && te < 0; t++) begin
            if (t - ta > LATE) begin
               te = ta + LATE + 1;
               kind = bq.size() == 0 ? 1 : 2;
            end else if (lv[t] != lv[t-1]) begin
               if (t - ta < EARLY) begin
                  early++;
                  if (early == 2) te = t;
               end else begin
                  bq.push_back(!lv[t]);
                  ta = t;
                  early = 0;
                  if (bq.size() == 8) begin
                     v = '0;
                     for (int b = 0; b < 8; b++) v[b] = bq[b];
                     exp_q.push_back('{0, v, base + t + 2});
                     bq.delete();
                  end
               end
            end
         end
         if (te < 0) begin
            te = ta + LATE + 1;
            kind = bq.size() == 0 ? 1 : 2;
         end
         exp_q.push_back('{kind, 8'h00, base + te + 2});
         run = 0;
         j = te + 1;
         while (j < n && run < BC) begin
            run = lv[j] ? run + 1 : 0;
            j++;
         end
      end
   endfunction

   function automatic int rh(input int h);
      return h != 0 ? h : int'($urandom_range(6, 10));
   endfunction

   task automatic put(input bit v, input int k);
      repeat (k) lv.push_back(v);
   endtask

   task automatic send_bit(input bit b, input int h1, input int h2);
      put(b, rh(h1));
      put(!b, rh(h2));
   endtask

   task automatic send_byte(input logic [7:0] v, input int h);
      for (int i = 0; i < 8; i++) send_bit(v[i], h, h);
   endtask

   task automatic play(input bit predict);
      int base;
      @(negedge clk);
      base = cyc + 1;
      if (predict) model(base);
      foreach (lv[i]) begin
         if (i > 0) @(negedge clk);
         rx.rxd = lv[i];
      end
      lv.delete();
   endtask

   task automatic drain(input string name);
      repeat (4) @(negedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data"}, int'(rx.data), 0);
      chk({tag, "_data_valid"}, int'(rx.data_valid), 0);
      chk({tag, "_cardet"}, int'(rx.cardet), 0);
      chk({tag, "_eof"}, int'(rx.eof), 0);
      chk({tag, "_error"}, int'(rx.error), 0);
   endtask

   always @(negedge clk) begin
      ev_t e;
      int k;
      if (reset && (rx.data_valid || rx.eof || rx.error)) begin
         k = rx.data_valid ? 0 : rx.eof ? 1 : 2;
         chk("one_pulse", int'(rx.data_valid) + int'(rx.eof) + int'(rx.error), 1);
         if (exp_q.size() == 0) chk("unexpected_event", k, 9);
         else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_cycle", cyc, e.at);
            if (k == 0) chk("data", int'(rx.data), int'(e.data));
            chk("cardet_at_event", int'(rx.cardet), int'(k == 0));
         end
      end
   end

   initial begin
      rx.rxd = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      put(1, 20); send_byte(8'h55, 8); send_byte(8'hA3, 8); put(1, 2 * BC + 40);
      play(1); drain("nominal");
      put(1, 20); send_byte(8'h55, 10); send_byte(8'hFF, 10); put(1, 60);
      play(1); drain("slow");
      put(1, 20); send_byte(8'h55, 6); send_byte(8'hFF, 6); put(1, 60);
      play(1); drain("fast");
      put(1, 20); send_byte(8'h55, 8); send_bit(1, 8, 8); send_bit(0, 8, 8); send_bit(1, 8, 8);
      put(1, 60);
      play(1); drain("partial");
      for (int hi = 7; hi <= 8; hi++) begin
         put(1, 20); send_bit(1, 8, 8); send_bit(0, 8, 8);
         put(1, 2); put(0, 1); put(1, 5); put(0, 8);
         put(1, hi); send_byte(8'h55, 8); put(1, 60);
         play(1); drain("glitch");
      end
      put(1, 20);
      for (int i = 0; i < 5; i++) send_bit(i % 2 == 0, 8, 8);
      put(1, 4);
      play(0);
      chk("cardet_mid_frame", int'(rx.cardet), 1);
      #2 reset = 1'b0;
      #1 check_zero("async_reset");
      rx.rxd = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      put(1, 20); send_byte(8'h55, 8); put(1, 60);
      play(1); drain("after_reset");
      repeat (8) begin
         put(1, $urandom_range(20, 40));
         send_byte(8'h55, 0);
         repeat ($urandom_range(0, 2)) send_byte(8'($urandom), 0);
         repeat ($urandom_range(0, 3)) send_bit(1'($urandom), 0, 0);
         put(1, 60);
         play(1); drain("random");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
